// File: rtl/hash_pkg.sv
// Shared definitions for the SHA-256/SHA-384 hash-state sequencer:
// state encoding, state-register op codes and default round counts.
`timescale 1ns/1ps
package hash_pkg;

   localparam int NR256_DEF = 64;
   localparam int NR384_DEF = 80;
   localparam int BCW_DEF   = 16;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_INIT     = 3'd1,
      ST_WAIT_BLK = 3'd2,
      ST_ROUND    = 3'd3,
      ST_UPD      = 3'd4,
      ST_FINAL    = 3'd5,
      ST_DONE     = 3'd6,
      ST_CLR      = 3'd7
   } state_t;

   localparam logic [1:0] LST_EXT = 2'b00;
   localparam logic [1:0] LST_H0  = 2'b01;
   localparam logic [1:0] LST_FIN = 2'b10;
   localparam logic [1:0] LST_ACC = 2'b11;

endpackage

// File: rtl/hash_seq_ctrl.sv
// Hash-state sequencer: accepts message blocks, steps the compression core
// through 64/80 rounds per block and drives the hash-state register controls.
`timescale 1ns/1ps
module hash_seq_ctrl
   import hash_pkg::*;
#(
   parameter int NR256 = NR256_DEF,
   parameter int NR384 = NR384_DEF,
   parameter int BCW   = BCW_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           resume,
   input  logic           mode_384,
   input  logic           abort,
   input  logic           blk_valid,
   input  logic           blk_last,
   output logic           blk_ready,
   output logic           rnd_en,
   output logic [6:0]     rnd_idx,
   output logic           rnd_first,
   output logic           h_flg_384,
   output logic [1:0]     lst_op,
   output logic           lst_en,
   output logic           h_clr,
   output logic           busy,
   output logic           done,
   output logic [BCW-1:0] blk_cnt
);

   localparam logic [6:0]     LAST256 = 7'(NR256 - 1);
   localparam logic [6:0]     LAST384 = 7'(NR384 - 1);
   localparam logic [BCW-1:0] CNT_ONE = BCW'(1);
   localparam logic [BCW-1:0] CNT_MAX = {BCW{1'b1}};

   state_t         state_q, state_d;
   logic           mode_q, mode_d;
   logic           resume_q, resume_d;
   logic           last_q, last_d;
   logic [6:0]     idx_q, idx_d;
   logic [BCW-1:0] cnt_q, cnt_d;

   logic           blk_ready_q, blk_ready_d;
   logic           rnd_en_q, rnd_en_d;
   logic           rnd_first_q, rnd_first_d;
   logic [1:0]     lst_op_q, lst_op_d;
   logic           lst_en_q, lst_en_d;
   logic           h_clr_q, h_clr_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   logic [6:0]     last_idx_s;

   assign last_idx_s = mode_q ? LAST384 : LAST256;

   // Next-state and counter update; abort overrides everything, even start in IDLE.
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      resume_d = resume_q;
      last_d   = last_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      if (abort) begin
         state_d = ST_CLR;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d  = ST_INIT;
                  mode_d   = mode_384;
                  resume_d = resume;
                  cnt_d    = {BCW{1'b0}};
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_INIT:     state_d = ST_WAIT_BLK;
            ST_WAIT_BLK: begin
               if (blk_valid) begin
                  state_d = ST_ROUND;
                  last_d  = blk_last;
                  idx_d   = 7'd0;
                  if (cnt_q != CNT_MAX) begin
                     cnt_d = cnt_q + CNT_ONE;
                  end else begin
                     cnt_d = cnt_q;
                  end
               end else begin
                  state_d = ST_WAIT_BLK;
               end
            end
            ST_ROUND: begin
               if (idx_q == last_idx_s) begin
                  state_d = ST_UPD;
               end else begin
                  idx_d = idx_q + 7'd1;
               end
            end
            ST_UPD:   state_d = last_q ? ST_FINAL : ST_WAIT_BLK;
            ST_FINAL: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            ST_CLR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Outputs decoded from the next state so they register in step with it.
   always_comb begin
      blk_ready_d = 1'b0;
      rnd_en_d    = 1'b0;
      rnd_first_d = 1'b0;
      lst_op_d    = LST_EXT;
      lst_en_d    = 1'b0;
      h_clr_d     = 1'b0;
      busy_d      = (state_d != ST_IDLE);
      done_d      = 1'b0;
      case (state_d)
         ST_INIT: begin
            lst_en_d = 1'b1;
            lst_op_d = resume_d ? LST_EXT : LST_H0;
         end
         ST_WAIT_BLK: blk_ready_d = 1'b1;
         ST_ROUND: begin
            rnd_en_d    = 1'b1;
            rnd_first_d = (idx_d == 7'd0);
         end
         ST_UPD: begin
            lst_en_d = 1'b1;
            lst_op_d = LST_ACC;
         end
         ST_FINAL: begin
            lst_en_d = 1'b1;
            lst_op_d = LST_FIN;
         end
         ST_DONE: done_d  = 1'b1;
         ST_CLR:  h_clr_d = 1'b1;
         default: busy_d  = (state_d != ST_IDLE);
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         mode_q      <= 1'b0;
         resume_q    <= 1'b0;
         last_q      <= 1'b0;
         idx_q       <= 7'd0;
         cnt_q       <= {BCW{1'b0}};
         blk_ready_q <= 1'b0;
         rnd_en_q    <= 1'b0;
         rnd_first_q <= 1'b0;
         lst_op_q    <= LST_EXT;
         lst_en_q    <= 1'b0;
         h_clr_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         resume_q    <= resume_d;
         last_q      <= last_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         blk_ready_q <= blk_ready_d;
         rnd_en_q    <= rnd_en_d;
         rnd_first_q <= rnd_first_d;
         lst_op_q    <= lst_op_d;
         lst_en_q    <= lst_en_d;
         h_clr_q     <= h_clr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign blk_ready = blk_ready_q;
   assign rnd_en    = rnd_en_q;
   assign rnd_idx   = idx_q;
   assign rnd_first = rnd_first_q;
   assign h_flg_384 = mode_q;
   assign lst_op    = lst_op_q;
   assign lst_en    = lst_en_q;
   assign h_clr     = h_clr_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign blk_cnt   = cnt_q;

endmodule
